// File: rtl/reversible_add_sequencer.sv
// reversible_add_sequencer: byte-serial multi-precision add through a shared registered 8-bit adder
module reversible_add_sequencer #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy,
  output logic         add_enable,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic [7:0]   add_anc,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic          c;
  logic [W-1:0]  a_r, b_r, sum_r;
  logic [7:0]    a_last, b_last;
  logic          cin_last;
  assign in_ready   = state == IDLE;
  assign busy       = state != IDLE;
  assign out_valid  = state == DONE;
  assign add_enable = state == ISSUE;
  assign add_anc    = '0;
  assign add_a      = add_enable ? a_r[8*idx +: 8] : a_last;
  assign add_b      = add_enable ? b_r[8*idx +: 8] : b_last;
  assign add_cin    = add_enable ? c : cin_last;
  assign out_sum    = sum_r;
  assign out_cout   = c;
  // next state: issue/wait/capture per byte, clear overrides everything
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = CAPT;
      CAPT:    state_n = idx == LAST ? DONE : ISSUE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end
  // state, operand latch, carry chain and result assembly; adder inputs hold their last driven value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      c        <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      a_last   <= '0;
      b_last   <= '0;
      cin_last <= 1'b0;
    end else begin
      state    <= state_n;
      a_last   <= add_a;
      b_last   <= add_b;
      cin_last <= add_cin;
      if (!clear && state == IDLE && in_valid) begin
        a_r <= in_a;
        b_r <= in_b;
        c   <= in_cin;
        idx <= '0;
      end
      if (!clear && state == CAPT) begin
        sum_r[8*idx +: 8] <= add_sum;
        c                 <= add_cout;
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reversible_add_sequencer.sv
// tb_reversible_add_sequencer: directed and random checks of the byte-serial add sequencer
module tb_reversible_add_sequencer;
  localparam int N = 4;
  localparam int W = 8 * N;
  logic clk = 0, reset = 1;
  logic clear = 0, in_valid = 0, in_cin = 0, out_ready = 0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout, busy, add_enable, add_cin, w_cout = 0;
  logic [W-1:0] out_sum;
  logic [7:0] add_a, add_b, add_anc, w_sum = '0;
  logic c1_in_valid = 0, c1_in_cin = 0, c1_out_ready = 0, c1_clear = 0;
  logic [7:0] c1_in_a = '0, c1_in_b = '0;
  logic c1_in_ready, c1_out_valid, c1_out_cout, c1_busy, c1_en, c1_cin, w1_cout = 0;
  logic [7:0] c1_out_sum, c1_a, c1_b, c1_anc, w1_sum = '0;
  int checks = 0, failures = 0;
  int phase = -1;
  logic [W-1:0] ea = '0, eb = '0;
  logic ecin = 0;
  logic [W:0] esum = '0;
  logic [7:0] la = '0, lb = '0;
  logic lc = 0;
  logic [3:0] cin_log = '0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  reversible_add_sequencer #(.NBYTES(N)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy), .add_enable(add_enable),
    .add_a(add_a), .add_b(add_b), .add_anc(add_anc), .add_cin(add_cin),
    .add_sum(w_sum), .add_cout(w_cout));

  reversible_add_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .reset(reset), .clear(c1_clear), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_a(c1_in_a), .in_b(c1_in_b), .in_cin(c1_in_cin), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
    .out_sum(c1_out_sum), .out_cout(c1_out_cout), .busy(c1_busy), .add_enable(c1_en),
    .add_a(c1_a), .add_b(c1_b), .add_anc(c1_anc), .add_cin(c1_cin),
    .add_sum(w1_sum), .add_cout(w1_cout));

  // registered 8-bit adder wrappers driven by each sequencer
  always @(posedge clk) begin
    if (add_enable) {w_cout, w_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    if (c1_en) {w1_cout, w1_sum} <= {1'b0, c1_a} + {1'b0, c1_b} + {8'd0, c1_cin};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic en_exp();
    return phase >= 0 && phase < 3 * N && phase % 3 == 0;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int j);
    return v[8*j +: 8];
  endfunction

  // carry into byte j is the overflow of the lower j bytes added as plain integers
  function automatic logic carry_into(input int j);
    logic [63:0] m;
    m = (64'd1 << (8 * j)) - 64'd1;
    return 1'(((64'(ea) & m) + (64'(eb) & m) + 64'(ecin)) >> (8 * j));
  endfunction

  // transaction-level model: cycles elapsed since accept, result known at accept
  always @(posedge clk or posedge reset) begin
    if (reset) phase <= -1;
    else if (clear) phase <= -1;
    else if (phase < 0) begin
      if (in_valid) begin
        phase <= 0;
        ea <= in_a;
        eb <= in_b;
        ecin <= in_cin;
        esum <= {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      end
    end else if (phase < 3 * N) phase <= phase + 1;
    else if (out_ready) phase <= -1;
  end

  // per-cycle comparison of the N=4 instance against the model
  always @(negedge clk) begin
    if (reset) begin
      la <= '0;
      lb <= '0;
      lc <= 1'b0;
    end else begin
      chk("in_ready", in_ready, phase < 0);
      chk("busy", busy, phase >= 0);
      chk("out_valid", out_valid, phase == 3 * N);
      chk("add_enable", add_enable, en_exp());
      chk("add_anc", add_anc, 0);
      chk("add_a", add_a, en_exp() ? byte_of(ea, phase / 3) : la);
      chk("add_b", add_b, en_exp() ? byte_of(eb, phase / 3) : lb);
      chk("add_cin", add_cin, en_exp() ? carry_into(phase / 3) : lc);
      if (en_exp()) begin
        la <= byte_of(ea, phase / 3);
        lb <= byte_of(eb, phase / 3);
        lc <= carry_into(phase / 3);
      end
      if (phase == 3 * N) begin
        chk("out_sum", out_sum, esum[W-1:0]);
        chk("out_cout", out_cout, esum[W]);
      end
    end
    if (add_enable) begin
      en_cnt <= en_cnt + 1;
      cin_log <= {add_cin, cin_log[3:1]};
    end
  end

  task automatic run_op(input logic [W-1:0] a, b, input logic ci, input logic [W-1:0] es, input logic ec, input string nm);
    int n;
    in_a = a;
    in_b = b;
    in_cin = ci;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 12);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_cout"}, out_cout, ec);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic run_op1(input logic [7:0] a, b, input logic ci, input logic [7:0] es, input logic ec, input string nm);
    int n;
    c1_in_a = a;
    c1_in_b = b;
    c1_in_cin = ci;
    c1_in_valid = 1;
    @(posedge clk); #1;
    c1_in_valid = 0;
    n = 0;
    while (!c1_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_sum"}, c1_out_sum, es);
    chk({nm, "_cout"}, c1_out_cout, ec);
    chk({nm, "_anc"}, c1_anc, 0);
    c1_out_ready = 1;
    @(posedge clk); #1;
    c1_out_ready = 0;
  endtask

  initial begin
    int n, e0;
    logic seen;
    logic [W-1:0] rec;
    logic [W:0] ex;
    logic [8:0] ex1;
    logic [7:0] r1a, r1b;
    logic [W-1:0] ra, rb;
    logic rc;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", add_enable, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst1_in_ready", c1_in_ready, 1);
    reset = 0;
    @(posedge clk); #1;

    run_op(32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0008, 0, "small");

    e0 = en_cnt;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, "ripple");
    chk("ripple_cin_seq", cin_log, 4'b1110);
    chk("ripple_pulses", en_cnt - e0, 4);

    e0 = en_cnt;
    run_op(32'h1234_5678, 32'hEDCB_A987, 1, 32'h0000_0000, 1, "cin_only");
    chk("cin_only_pulses", en_cnt - e0, 4);

    in_a = 32'h8000_0001;
    in_b = 32'h8000_00FF;
    in_cin = 0;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_sum", out_sum, 32'h0000_0100);
    chk("bp_cout", out_cout, 1);
    rec = out_sum;
    in_a = 32'h1111_1111;
    in_valid = 1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", out_sum, rec);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_idle_after", in_ready, 1);
    run_op(32'h0000_00FF, 32'h0000_0001, 1, 32'h0000_0101, 0, "after_bp");

    in_a = 32'h0102_0304;
    in_b = 32'h1010_1010;
    in_cin = 0;
    in_valid = 1;
    clear = 1;
    @(posedge clk); #1;
    chk("clear_blocks_accept", busy, 0);
    clear = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("accept_after_clear", busy, 1);
    repeat (4) @(posedge clk);
    #1 clear = 1;
    @(posedge clk); #1;
    clear = 0;
    chk("abort_idle", in_ready, 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("abort_no_valid", seen, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, "after_abort");

    in_a = 32'hAAAA_AAAA;
    in_b = 32'h5555_5555;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_in_ready", in_ready, 1);
    chk("areset_enable", add_enable, 0);
    chk("areset_out_sum", out_sum, 0);
    chk("areset_add_a", add_a, 0);
    chk("areset_add_cin", add_cin, 0);
    #5 reset = 0;
    run_op(32'h0000_0010, 32'h0000_0020, 1, 32'h0000_0031, 0, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, ex[W-1:0], ex[W], "rand4");
    end

    run_op1(8'hFF, 8'h01, 0, 8'h00, 1, "n1_ripple");
    run_op1(8'hFF, 8'hFF, 1, 8'hFF, 1, "n1_max");
    run_op1(8'h05, 8'h03, 0, 8'h08, 0, "n1_small");
    for (int i = 0; i < 1000; i++) begin
      r1a = 8'($urandom);
      r1b = 8'($urandom);
      rc = 1'($urandom);
      ex1 = {1'b0, r1a} + {1'b0, r1b} + {8'd0, rc};
      run_op1(r1a, r1b, rc, ex1[7:0], ex1[8], "rand1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
